// File: rtl/rr_dec_arbiter_pkg.sv
// Shared types and sizing for the 8-way round-robin arbiter.
package rr_dec_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/rr_dec_arbiter_dec.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8_case (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (en) begin
            case (in)
                3'd0: out = 8'h01;
                3'd1: out = 8'h02;
                3'd2: out = 8'h04;
                3'd3: out = 8'h08;
                3'd4: out = 8'h10;
                3'd5: out = 8'h20;
                3'd6: out = 8'h40;
                3'd7: out = 8'h80;
                default: out = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for 8 requesters with hold-until-done, drop-out and hold timeout.
//   state | meaning
//   IDLE  | no grant held; pick next winner from req starting at ptr
//   BUSY  | grant held for grant_idx until done, drop-out or MAX_HOLD cycles
module rr_dec_arbiter
    import rr_dec_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   win_off;
    logic [IDX_W-1:0]   win_idx;

    logic rel_drop;
    logic rel_limit;
    logic release_now;
    logic timeout_only;

    // Rotate so ptr lands at bit 0, take lowest set bit, then rotate back.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N_REQ-1:0];
        win_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) win_off = IDX_W'(i);
        end
        win_idx = ptr + win_off;
    end

    assign rel_drop     = ~req[grant_idx];
    assign rel_limit    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now  = done | rel_drop | rel_limit;
    assign timeout_only = rel_limit & ~done & ~rel_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                        ptr         <= idx_inc(grant_idx);
                        hold_cnt    <= '0;
                        timeout     <= timeout_only;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                        timeout  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Grant is decoded purely from registered state, never from req.
    dec3to8_case u_dec (
        .in  (grant_idx),
        .en  (grant_valid),
        .out (grant)
    );

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Directed self-checking bench for rr_dec_arbiter with MAX_HOLD=15.
module tb_rr_dec_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout;

    int n_chk  = 0;
    int n_pass = 0;

    rr_dec_arbiter #(.MAX_HOLD(15)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_g;

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;

        // 1: reset values with requests pending, before any clock edge
        #3;
        chk("rst_grant", grant, 8'h00);
        chk("rst_gv", {7'b0, grant_valid}, 8'h00);
        chk("rst_idx", {5'b0, grant_idx}, 8'h00);
        chk("rst_to", {7'b0, timeout}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t1_first", grant, 8'h01);
        req = 8'h00;
        step();
        chk("t1_drop", grant, 8'h00);
        chk("t1_drop_to", {7'b0, timeout}, 8'h00);

        // 2: two requesters, done a few cycles into the grant
        pulse_reset();
        req = 8'b0000_0101;
        step();
        chk("t2_g0", grant, 8'h01);
        step();
        step();
        chk("t2_hold", grant, 8'h01);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t2_gap", grant, 8'h00);
        step();
        chk("t2_g2", grant, 8'h04);
        chk("t2_idx", {5'b0, grant_idx}, 8'h02);
        done = 1'b1;
        req  = 8'h00;
        step();
        done = 1'b0;
        chk("t2_end", grant, 8'h00);

        // 3: all requesting, done every grant cycle, full rotation plus wrap
        pulse_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_g = 8'h01 << (i % 8);
            step();
            chk($sformatf("t3_g%0d", i), grant, exp_g);
            step();
            chk($sformatf("t3_gap%0d", i), grant, 8'h00);
        end
        done = 1'b0;
        req  = 8'h00;
        step();

        // 4: single requester never finishes -> 15-cycle grant then timeout
        pulse_reset();
        req = 8'h08;
        step();
        chk("t4_c1", grant, 8'h08);
        for (int c = 2; c <= 15; c++) begin
            step();
            chk($sformatf("t4_c%0d", c), grant, 8'h08);
            chk($sformatf("t4_to%0d", c), {7'b0, timeout}, 8'h00);
        end
        step();
        chk("t4_rel", grant, 8'h00);
        chk("t4_to", {7'b0, timeout}, 8'h01);
        step();
        chk("t4_regrant", grant, 8'h08);
        chk("t4_to_clr", {7'b0, timeout}, 8'h00);

        // 5: done coincides with the last allowed cycle -> no timeout
        req = 8'h48;
        for (int c = 1; c <= 14; c++) step();
        chk("t5_last", grant, 8'h08);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t5_rel", grant, 8'h00);
        chk("t5_to", {7'b0, timeout}, 8'h00);
        step();
        chk("t5_next", grant, 8'h40);
        req = 8'h00;
        step();

        // 6: requester drop-out, then asynchronous reset mid-grant
        pulse_reset();
        req = 8'h84;
        step();
        chk("t6_g2", grant, 8'h04);
        req = 8'h80;
        step();
        chk("t6_drop", grant, 8'h00);
        chk("t6_to", {7'b0, timeout}, 8'h00);
        step();
        chk("t6_g7", grant, 8'h80);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_g", grant, 8'h00);
        chk("t6_arst_gv", {7'b0, grant_valid}, 8'h00);
        chk("t6_arst_idx", {5'b0, grant_idx}, 8'h00);
        rst_n = 1'b1;
        req   = 8'h00;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
